// File: rtl/mext_pkg.sv
// Shared encodings for the RV32M execute-stage sequencer: FSM states, funct3 decode,
// unit opcodes and the signed-overflow operand constants.
package mext_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MUL_WAIT = 3'd1,
    ST_DIV_WAIT = 3'd2,
    ST_DONE     = 3'd3,
    ST_DRAIN    = 3'd4
  } state_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [1:0] MUL_OP_SS = 2'b00;
  localparam logic [1:0] MUL_OP_SU = 2'b01;
  localparam logic [1:0] MUL_OP_UU = 2'b10;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

  // MUL and MULH both need the signed x signed product; they differ only in the half taken.
  function automatic logic [1:0] mul_opcode_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b10:   return MUL_OP_SU;
      2'b11:   return MUL_OP_UU;
      default: return MUL_OP_SS;
    endcase
  endfunction

endpackage

// File: rtl/mext_special_case.sv
// Combinational detection of divide-by-zero and signed-overflow divides, with the
// architecturally defined result so the divider never has to be started for them.
module mext_special_case
  import mext_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            hit,
  output logic [XLEN-1:0] value
);

  always_comb begin
    hit   = 1'b0;
    value = '0;
    if (funct3[2]) begin
      if (rs2 == '0) begin
        hit   = 1'b1;
        value = funct3[1] ? rs1 : '1;
      end else if (!funct3[0] && rs1 == INT_MIN && rs2 == NEG_ONE) begin
        hit   = 1'b1;
        value = funct3[1] ? '0 : INT_MIN;
      end
    end
  end

endmodule

// File: rtl/mext_sequencer.sv
// RV32M execute-stage controller: decodes the M-op, launches one iterative unit,
// stalls the pipeline until its result returns, drains on flush and bounds every wait.
module mext_sequencer
  import mext_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [2:0]        ex_funct3,
  input  logic [XLEN-1:0]   ex_rs1,
  input  logic [XLEN-1:0]   ex_rs2,
  input  logic              flush,
  output logic              mul_start,
  output logic [1:0]        mul_opcode,
  output logic              div_start,
  output logic [1:0]        div_opcode,
  output logic [XLEN-1:0]   unit_op1,
  output logic [XLEN-1:0]   unit_op2,
  input  logic              mul_ready,
  input  logic [2*XLEN-1:0] mul_result,
  input  logic              div_ready,
  input  logic [XLEN-1:0]   div_result,
  output logic              stall,
  output logic              result_valid,
  output logic [XLEN-1:0]   result,
  output logic              timeout_err
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e            state_q, state_d;
  logic [2:0]        funct3_q;
  logic [WD_W-1:0]   wd_cnt_q;
  logic [XLEN-1:0]   result_q;
  logic              sc_hit;
  logic [XLEN-1:0]   sc_value;
  logic              launch;
  logic              unit_ready;
  logic              wd_expired;
  logic [XLEN-1:0]   unit_value;

  mext_special_case #(.XLEN(XLEN)) u_special_case (
    .funct3 (ex_funct3),
    .rs1    (ex_rs1),
    .rs2    (ex_rs2),
    .hit    (sc_hit),
    .value  (sc_value)
  );

  always_comb begin
    launch     = (state_q == ST_IDLE) && ex_valid && !flush;
    unit_ready = funct3_q[2] ? div_ready : mul_ready;
    wd_expired = (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));
    if (funct3_q[2])
      unit_value = div_result;
    else if (funct3_q[1:0] == 2'b00)
      unit_value = mul_result[XLEN-1:0];
    else
      unit_value = mul_result[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d      = state_q;
    stall        = 1'b0;
    result_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall = launch;
        if (launch)
          state_d = sc_hit ? ST_DONE : (ex_funct3[2] ? ST_DIV_WAIT : ST_MUL_WAIT);
      end
      ST_MUL_WAIT, ST_DIV_WAIT: begin
        stall = !flush;
        // A flush that coincides with completion has nothing left to drain.
        if (flush)
          state_d = (unit_ready || wd_expired) ? ST_IDLE : ST_DRAIN;
        else if (unit_ready || wd_expired)
          state_d = ST_DONE;
      end
      ST_DONE: begin
        result_valid = !flush;
        state_d      = ST_IDLE;
      end
      ST_DRAIN: begin
        stall = ex_valid && !flush;
        if (unit_ready || wd_expired)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      funct3_q    <= '0;
      wd_cnt_q    <= '0;
      result_q    <= '0;
      mul_start   <= 1'b0;
      div_start   <= 1'b0;
      mul_opcode  <= '0;
      div_opcode  <= '0;
      unit_op1    <= '0;
      unit_op2    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      mul_start <= 1'b0;
      div_start <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (launch) begin
            unit_op1 <= ex_rs1;
            unit_op2 <= ex_rs2;
            funct3_q <= ex_funct3;
            wd_cnt_q <= '0;
            if (sc_hit) begin
              result_q <= sc_value;
            end else if (ex_funct3[2]) begin
              div_start  <= 1'b1;
              div_opcode <= ex_funct3[1:0];
            end else begin
              mul_start  <= 1'b1;
              mul_opcode <= mul_opcode_of(ex_funct3);
            end
          end
        end
        ST_MUL_WAIT, ST_DIV_WAIT: begin
          if (unit_ready) begin
            if (!flush)
              result_q <= unit_value;
          end else if (wd_expired) begin
            if (!flush)
              result_q <= '0;
            timeout_err <= 1'b1;
          end else begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (!unit_ready) begin
            if (wd_expired)
              timeout_err <= 1'b1;
            else
              wd_cnt_q <= wd_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign result = result_q;

endmodule
